// File: rtl/display_mux_driver.sv
// Multiplexed 7-segment display driver.
// A binary value is accepted through a valid/ready handshake and converted to BCD
// by a serial double-dabble engine (one step per clock). The result is committed
// atomically into the display register. A free-running prescaler cycles through
// the digits, driving active-low anode enables and active-low segment patterns.
module display_mux_driver #(
  parameter int N_DIGITS    = 4,
  parameter int IN_W        = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_W-1:0]     valor_in,
  input  logic                valor_valid,
  output logic                valor_ready,
  input  logic                blank_lz,
  output logic [7:0]          catodo,
  output logic [N_DIGITS-1:0] anodo,
  output logic                ovf
);

  // Nine BCD digits cover the widest legal input (2^27-1 has nine decimal digits).
  localparam int BCD_D  = 9;
  localparam int BCD_W  = 4 * BCD_D;
  localparam int DD_W   = BCD_W + IN_W;
  localparam int DISP_W = 4 * N_DIGITS;
  localparam int CNT_W  = $clog2(IN_W + 1);
  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  localparam logic [7:0] SEG_DASH  = 8'b11111101;
  localparam logic [7:0] SEG_BLANK = 8'b11111111;

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Largest value that fits on the display.
  localparam logic [31:0] LIMIT = 32'(pow10(N_DIGITS) - 1);

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_D; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low segment pattern, bit7=a .. bit1=g, bit0=dp.
  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 8'b00000011;
      4'd1:    seg = 8'b10011111;
      4'd2:    seg = 8'b00100101;
      4'd3:    seg = 8'b00001101;
      4'd4:    seg = 8'b10011001;
      4'd5:    seg = 8'b01001001;
      4'd6:    seg = 8'b01000001;
      4'd7:    seg = 8'b00011111;
      4'd8:    seg = 8'b00000001;
      4'd9:    seg = 8'b00011001;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t              state, state_nx;
  logic                accept;
  logic [DD_W-1:0]     dd;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_cap;
  logic [DISP_W-1:0]   disp;
  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [N_DIGITS-1:0] blank;
  logic                lead;
  logic [3:0]          cur_digit;
  logic                cur_blank;

  assign accept = valor_valid && valor_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state: IDLE waits for an accept, CONV runs IN_W steps, COMMIT lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CONV;
      CONV:    if (cnt == CNT_LAST) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: a new value is only taken while idle.
  always_comb begin
    valor_ready = (state == IDLE);
  end

  // Conversion datapath: {bcd, binary} shift register, loaded on accept and stepped in CONV.
  always_ff @(posedge clk) begin
    if (accept) begin
      dd      <= {{BCD_W{1'b0}}, valor_in};
      cnt     <= '0;
      ovf_cap <= ({{(32-IN_W){1'b0}}, valor_in} > LIMIT);
    end else if (state == CONV) begin
      dd  <= {add3(dd[DD_W-1 -: BCD_W]), dd[IN_W-1:0]} << 1;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Display register: only updated on COMMIT, so partial BCD is never shown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp <= '0;
      ovf  <= 1'b0;
    end else if (state == COMMIT) begin
      disp <= dd[IN_W +: DISP_W];
      ovf  <= ovf_cap;
    end
  end

  // Refresh prescaler and digit index; free-running, independent of the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Digit selection, leading-zero blanking and segment decode for the active digit.
  always_comb begin
    lead      = 1'b1;
    blank     = '0;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lead     = lead && (disp[4*i +: 4] == 4'd0);
      blank[i] = lead && (i != 0) && blank_lz;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = disp[4*i +: 4];
        cur_blank = blank[i];
      end
    end
    anodo = ~(N_DIGITS'(1) << idx);
    if (ovf)            catodo = SEG_DASH;
    else if (cur_blank) catodo = SEG_BLANK;
    else                catodo = seg(cur_digit);
  end

endmodule

// File: tb/tb_display_mux_driver.sv
// Self-checking bench for display_mux_driver (N_DIGITS=4, IN_W=14, REFRESH_DIV=4).
// Expected displays are queued when a value is driven and compared after commit.
module tb_display_mux_driver;

  localparam int N_DIGITS    = 4;
  localparam int IN_W        = 14;
  localparam int REFRESH_DIV = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [IN_W-1:0]     valor_in = '0;
  logic                valor_valid = 1'b0;
  logic                valor_ready;
  logic                blank_lz = 1'b0;
  logic [7:0]          catodo;
  logic [N_DIGITS-1:0] anodo;
  logic                ovf;

  always #5 clk = ~clk;

  display_mux_driver #(
    .N_DIGITS   (N_DIGITS),
    .IN_W       (IN_W),
    .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valor_in   (valor_in),
    .valor_valid(valor_valid),
    .valor_ready(valor_ready),
    .blank_lz   (blank_lz),
    .catodo     (catodo),
    .anodo      (anodo),
    .ovf        (ovf)
  );

  typedef struct packed {
    logic [31:0] v;
    logic        o;
  } exp_t;

  int          n_checks = 0;
  int          n_err = 0;
  int unsigned cyc;
  bit          scan_on = 1'b0;
  exp_t        sb[$];
  exp_t        prev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_ref(input int unsigned d);
    case (d)
      0: return 8'b00000011;
      1: return 8'b10011111;
      2: return 8'b00100101;
      3: return 8'b00001101;
      4: return 8'b10011001;
      5: return 8'b01001001;
      6: return 8'b01000001;
      7: return 8'b00011111;
      8: return 8'b00000001;
      9: return 8'b00011001;
      default: return 8'b11111111;
    endcase
  endfunction

  // Pattern expected on digit i for a committed value.
  function automatic logic [7:0] exp_cat(input exp_t e, input logic blz, input int i);
    int unsigned p;
    int unsigned v;
    p = 1;
    v = e.v;
    for (int j = 0; j < i; j++) p = p * 10;
    if (e.o) return 8'b11111101;
    if (blz && i > 0 && v < p) return 8'b11111111;
    return seg_ref((v / p) % 10);
  endfunction

  function automatic int cur_idx();
    return int'((cyc / REFRESH_DIV) % N_DIGITS);
  endfunction

  // Clock edges since the last reset; the digit index is a function of this count.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // The anode scan is checked on every cycle, across all accepts and conversions.
  always @(negedge clk) begin
    logic [3:0] e;
    if (scan_on) begin
      e = 4'b1111;
      e[cur_idx()] = 1'b0;
      chk("anodo_scan", 32'(anodo), 32'(e));
    end
  end

  // Drive one value (optionally holding valid with another value during conversion)
  // and check busy length, display hold, and the committed display.
  task automatic load(input int unsigned value, input bit blz, input bit hold,
                      input int unsigned hold_val, input bit align);
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!(valor_ready && (!align || (cyc % REFRESH_DIV) == REFRESH_DIV - 1)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_wait", 32'(valor_ready), 32'd1);
    valor_in    = value[IN_W-1:0];
    valor_valid = 1'b1;
    blank_lz    = blz;
    e.v = value;
    e.o = (value > 9999);
    sb.push_back(e);
    @(negedge clk);
    if (hold) valor_in = hold_val[IN_W-1:0];
    else      valor_valid = 1'b0;
    n = 0;
    while (!valor_ready && n < 100) begin
      chk($sformatf("hold_digit%0d", cur_idx()), 32'(catodo), 32'(exp_cat(prev, blank_lz, cur_idx())));
      n++;
      @(negedge clk);
    end
    valor_valid = 1'b0;
    chk("busy_cycles", 32'(n), 32'd15);
    e = sb.pop_front();
    chk("ovf", 32'(ovf), 32'(e.o));
    for (int j = 0; j < N_DIGITS * REFRESH_DIV; j++) begin
      chk($sformatf("v%0d_digit%0d", e.v, cur_idx()), 32'(catodo),
          32'(exp_cat(e, blank_lz, cur_idx())));
      @(negedge clk);
    end
    prev = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    prev = '0;
    // Reset asserted before any clock edge: outputs must already be in reset state.
    #2 reset = 1'b1;
    #1;
    chk("rst_catodo", 32'(catodo), 32'(8'b00000011));
    chk("rst_anodo", 32'(anodo), 32'(4'b1110));
    chk("rst_ready", 32'(valor_ready), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    scan_on = 1'b1;

    load(1234, 1'b0, 1'b0, 0, 1'b1);
    load(7, 1'b1, 1'b0, 0, 1'b0);
    load(7, 1'b0, 1'b0, 0, 1'b0);
    load(10000, 1'b0, 1'b0, 0, 1'b1);
    load(9999, 1'b0, 1'b0, 0, 1'b0);
    load(42, 1'b1, 1'b1, 777, 1'b0);
    load(16383, 1'b1, 1'b0, 0, 1'b0);
    load(0, 1'b1, 1'b0, 0, 1'b1);
    load(5678, 1'b0, 1'b0, 0, 1'b0);

    // Reset in the middle of a conversion discards the captured value.
    @(negedge clk);
    valor_in    = 14'd5555;
    valor_valid = 1'b1;
    @(negedge clk);
    chk("abort_accepted", 32'(valor_ready), 32'd0);
    valor_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_catodo", 32'(catodo), 32'(8'b00000011));
    chk("abort_anodo", 32'(anodo), 32'(4'b1110));
    chk("abort_ready", 32'(valor_ready), 32'd1);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    prev     = '0;
    blank_lz = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 24; j++) begin
      chk("post_abort_ready", 32'(valor_ready), 32'd1);
      chk($sformatf("post_abort_digit%0d", cur_idx()), 32'(catodo),
          32'(exp_cat(prev, blank_lz, cur_idx())));
      @(negedge clk);
    end

    load(321, 1'b1, 1'b0, 0, 1'b1);

    scan_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/display_mux_driver.md
DISPLAY_MUX_DRIVER -- requirements
Module: display_mux_driver

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter IN_W, default 14, binary input width; legal range 4..27.
REQ-003 Parameter REFRESH_DIV, default 50000, clock cycles each digit is held; legal range 2 and above.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 valor_in  in  IN_W  unsigned binary value to display.
REQ-007 valor_valid  in  1  request to load valor_in.
REQ-008 valor_ready  out  1  high when a new value is accepted.
REQ-009 blank_lz  in  1  enables leading-zero blanking; sampled every cycle.
REQ-010 catodo  out  8  segment pattern of the active digit, active-low; bit7=a .. bit1=g, bit0=dp.
REQ-011 anodo  out  N_DIGITS  digit enables, active-low one-hot; bit 0 is the least-significant digit.
REQ-012 ovf  out  1  high while the displayed value exceeds 10^N_DIGITS-1.

Function
REQ-013 Accept SHALL occur on an edge where valor_valid=1 and valor_ready=1; valor_in is captured there, and valor_valid is ignored at all other times.
REQ-014 FSM states SHALL be IDLE, CONV and COMMIT; valor_ready=1 only in IDLE.
REQ-015 IDLE SHALL go to CONV on accept; it otherwise holds.
REQ-016 CONV SHALL perform one shift-add-3 (double-dabble) step per cycle for exactly IN_W cycles, then go to COMMIT.
REQ-017 COMMIT SHALL, in one cycle, write the BCD result and the overflow flag into the display register and return to IDLE.
REQ-018 Latency: accept on edge k SHALL give updated catodo/ovf after edge k+IN_W+1, with valor_ready high again in that same cycle.
REQ-019 The display register SHALL hold the previous value unchanged throughout CONV; the display never shows partial results.
REQ-020 Overflow: if the captured value exceeds 10^N_DIGITS-1, the commit SHALL set ovf=1 and every digit SHALL show 11111101 (dash).
REQ-021 A non-overflow commit SHALL clear ovf.
REQ-022 Digit patterns SHALL be: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00011001; blank=11111111.
REQ-023 Leading-zero blanking: with blank_lz=1 and ovf=0, digit i>0 SHALL show blank when digits i..N_DIGITS-1 are all 0; digit 0 is never blanked.
REQ-024 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on the wrap edge the digit index SHALL increment modulo N_DIGITS (N_DIGITS-1 wraps to 0).
REQ-025 anodo SHALL be all ones except bit[index]=0; catodo SHALL be the pattern of digit[index]; both change on the same edge.
REQ-026 Multiplexing SHALL run continuously and independently of the FSM; accept, conversion and commit SHALL NOT disturb the prescaler or the index.
REQ-027 An accept coinciding with a prescaler wrap SHALL have both take effect normally.

Reset
REQ-028 On reset assertion, immediately and without a clock: FSM=IDLE, valor_ready=1, display register=all zero, ovf=0, prescaler=0, index=0, anodo=~1 (1110 for N_DIGITS=4), catodo=00000011.
REQ-029 Reset during CONV or COMMIT SHALL abort the conversion; the captured value is discarded and nothing is committed.
REQ-030 Deassertion SHALL be honoured on the next rising edge, with no spurious accept from a valor_valid that is already high.

Verification (N_DIGITS=4, IN_W=14, REFRESH_DIV=4)
REQ-031 Reset pulse -> catodo=00000011, anodo=1110, valor_ready=1, ovf=0.
REQ-032 Load 1234 -> valor_ready low for 15 cycles; scan shows idx0 10011001, idx1 00001101, idx2 00100101, idx3 10011111.
REQ-033 Load 7 with blank_lz=1 -> idx0 00011111, idx1..3 11111111; same value with blank_lz=0 -> idx1..3 00000011.
REQ-034 Load 10000 -> ovf=1, all digits 11111101; then load 9999 -> ovf=0, all digits 00011001.
REQ-035 Hold valor_valid during CONV with a different value -> that value is ignored; assert reset mid-CONV -> display 0000, valor_ready=1.
REQ-036 Free run -> anodo sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles, including across an accept.
